dmem_responder: RTL and testbench

- Data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel.
- Holds word-organised little-endian storage with byte/half/word write lanes.
- Inserts a programmable number of wait states so the pipeline's stall logic can be exercised.
- Returns raw load data right-aligned. The downstream load filter performs sign/zero extension.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channels between the MEM stage and the data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with byte/half/word lanes and programmable wait states
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
    output logic            busy
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  size;
    logic [31:0] mem [DEPTH_WORDS];

    logic          err;
    logic          commit;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [31:0]   rsel;

    // The range check is part of err, so an out-of-range idx is never used to commit or return data
    assign err    = size == 2'b11 || (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00) || addr >= 32'(DEPTH_WORDS * 4);
    assign idx    = addr[AW+1:2];
    assign commit = state == WAIT && cnt == 4'd0 && write && !err;
    assign be     = size == 2'b00 ? 4'b0001 << addr[1:0] :
                    size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wword  = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    assign rword  = mem[idx];
    // Aligned halves have addr[0]=0, so the byte shift also selects the right half
    assign rshift = rword >> {addr[1:0], 3'b000};
    assign rsel   = size == 2'b00 ? {24'b0, rshift[7:0]} : size == 2'b01 ? {16'b0, rshift[15:0]} : rword;

    // Storage is not reset; a store commits only on the edge that enters RESP
    always_ff @(posedge clk)
        if (commit)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];

    // Request/response FSM; WAIT always lasts LATENCY+1 edges so the response follows edge T+1+LATENCY
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            addr           <= 32'd0;
            wdata          <= 32'd0;
            write          <= 1'b0;
            size           <= 2'b00;
            busy           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    addr          <= bus.req_addr;
                    wdata         <= bus.req_wdata;
                    write         <= bus.req_write;
                    size          <= bus.req_size;
                    cnt           <= 4'(LATENCY);
                    state         <= WAIT;
                    busy          <= 1'b1;
                    bus.req_ready <= 1'b0;
                end
                WAIT: if (cnt == 4'd0) begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= err;
                    bus.resp_rdata <= err || write ? 32'd0 : rsel;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (bus.resp_ready) begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-level timeline model
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0] req_size = 2'b00;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    dmem_responder_if ia ();
    dmem_responder_if ib ();
    logic busy_a, busy_b;

    assign ia.req_valid  = req_valid & ~sel;
    assign ib.req_valid  = req_valid & sel;
    assign ia.resp_ready = resp_ready & ~sel;
    assign ib.resp_ready = resp_ready & sel;
    assign ia.req_addr   = req_addr;
    assign ib.req_addr   = req_addr;
    assign ia.req_write  = req_write;
    assign ib.req_write  = req_write;
    assign ia.req_size   = req_size;
    assign ib.req_size   = req_size;
    assign ia.req_wdata  = req_wdata;
    assign ib.req_wdata  = req_wdata;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ia), .busy(busy_a));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(ib), .busy(busy_b));

    logic d_ready, d_valid, d_busy, d_err;
    logic [31:0] d_rdata;
    assign d_ready = sel ? ib.req_ready  : ia.req_ready;
    assign d_valid = sel ? ib.resp_valid : ia.resp_valid;
    assign d_busy  = sel ? busy_b        : busy_a;
    assign d_err   = sel ? ib.resp_err   : ia.resp_err;
    assign d_rdata = sel ? ib.resp_rdata : ia.resp_rdata;

    // Model: byte memory per instance, one outstanding request, response after lat+1 edges
    logic [7:0] mm [2][4096];
    bit pend = 0, macc = 0;
    int age = 0, p_lat = 0, p_sel = 0;
    logic [31:0] p_addr, p_wd, e_rd;
    logic [1:0] p_sz;
    logic p_w, e_err;

    initial for (int s = 0; s < 2; s++) for (int a = 0; a < 4096; a++) mm[s][a] = 8'h00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend = 0;
            macc = 0;
        end else begin
            macc = 0;
            if (!pend) begin
                if (req_valid) begin
                    pend = 1; macc = 1; age = 0;
                    p_lat = sel ? 0 : 2; p_sel = sel ? 1 : 0;
                    p_addr = req_addr; p_wd = req_wdata; p_sz = req_size; p_w = req_write;
                    e_err = req_size == 2'd3 || (req_addr % (32'd1 << req_size)) != 0 || req_addr >= 32'd4096;
                    e_rd = 32'd0;
                    if (!e_err && !req_write)
                        for (int i = 0; i < (1 << req_size); i++)
                            e_rd = e_rd | (32'(mm[p_sel][req_addr + i]) << (8 * i));
                end
            end else if (age < p_lat + 1) begin
                age++;
                if (age == p_lat + 1 && p_w && !e_err)
                    for (int i = 0; i < (1 << p_sz); i++)
                        mm[p_sel][p_addr + i] = 8'(p_wd >> (8 * i));
            end else if (resp_ready) begin
                pend = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of the selected instance against the model
    always @(negedge clk) if (rst) begin
        chk("req_ready", 32'(d_ready), 32'(!pend));
        chk("resp_valid", 32'(d_valid), 32'(pend && age == p_lat + 1));
        chk("busy", 32'(d_busy), 32'(pend));
        if (pend && age == p_lat + 1) begin
            chk("resp_rdata", d_rdata, e_rd);
            chk("resp_err", 32'(d_err), 32'(e_err));
        end
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_addr = a; req_write = w; req_size = s; req_wdata = d; req_valid = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!macc && n < 50);
        checks++;
        if (!macc) begin fails++; $display("FAIL accept_timeout addr=%h", a); end
        req_valid = 1'b0;
    endtask

    task automatic recv(input int bp, output logic [31:0] rd, output logic er, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!d_valid && n < 50);
        checks++;
        if (!d_valid) begin fails++; $display("FAIL resp_timeout got=0 exp=1"); end
        rd = d_rdata; er = d_err;
        repeat (bp) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic xact(input string nm, input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [31:0] d, input logic [31:0] x_rd, input logic x_er);
        logic [31:0] rd; logic er; int n;
        send(a, w, s, d);
        recv(0, rd, er, n);
        chk({nm, "_rdata"}, rd, x_rd);
        chk({nm, "_err"}, 32'(er), 32'(x_er));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 32'(d_ready), 32'd1);
        chk("rst_resp_valid", 32'(d_valid), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_rdata", d_rdata, 32'd0);
        chk("rst_err", 32'(d_err), 32'd0);
    endtask

    task automatic random_phase(input int cycles);
        int r, k;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!req_valid || macc) begin
                req_valid = $urandom_range(0, 3) != 0;
                r = $urandom_range(0, 9);
                req_addr = r < 8 ? 32'($urandom_range(0, 63)) : r == 8 ? 32'($urandom_range(4088, 4095))
                                                                 : 32'($urandom_range(4096, 4200));
                req_write = $urandom_range(0, 1) != 0;
                req_size = 2'($urandom_range(0, 3));
                req_wdata = $urandom;
            end
            resp_ready = $urandom_range(0, 2) != 0;
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        k = 0;
        while (pend && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (pend) begin fails++; $display("FAIL drain_timeout got=1 exp=0"); end
        resp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd0;
        logic er;
        int n;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        sel = 1'b1;
        #1 chk_reset_outputs();
        sel = 1'b0;
        @(negedge clk) rst = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int a = 0; a < 64; a += 4) xact("init", 32'(a), 1'b1, 2'b10, 32'd0, 32'd0, 1'b0);
            xact("init_hi0", 32'hFF8, 1'b1, 2'b10, 32'd0, 32'd0, 1'b0);
            xact("init_hi1", 32'hFFC, 1'b1, 2'b10, 32'd0, 32'd0, 1'b0);
        end
        sel = 1'b0;

        send(32'h10, 1'b1, 2'b10, 32'hDEADBEEF);
        recv(0, rd, er, n);
        chk("first_latency", 32'(n), 32'd4);
        chk("first_rdata", rd, 32'd0);
        chk("first_err", 32'(er), 32'd0);

        xact("st_word20", 32'h20, 1'b1, 2'b10, 32'h11223344, 32'd0, 1'b0);
        xact("st_byte22", 32'h22, 1'b1, 2'b00, 32'h000000AA, 32'd0, 1'b0);
        xact("ld_word20", 32'h20, 1'b0, 2'b10, 32'd0, 32'h11AA3344, 1'b0);
        xact("ld_byte23", 32'h23, 1'b0, 2'b00, 32'd0, 32'h00000011, 1'b0);
        xact("ld_half22", 32'h22, 1'b0, 2'b01, 32'd0, 32'h000011AA, 1'b0);
        xact("st_half21", 32'h21, 1'b1, 2'b01, 32'h0000BBBB, 32'd0, 1'b1);
        xact("ld_word20b", 32'h20, 1'b0, 2'b10, 32'd0, 32'h11AA3344, 1'b0);
        xact("ld_word22", 32'h22, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
        xact("size3", 32'h20, 1'b0, 2'b11, 32'd0, 32'd0, 1'b1);
        xact("ld_1000", 32'h1000, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
        xact("ld_ffc", 32'hFFC, 1'b0, 2'b10, 32'd0, 32'd0, 1'b0);

        send(32'h10, 1'b0, 2'b10, 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!d_valid && n < 50);
        rd0 = d_rdata;
        chk("bp_first", rd0, 32'hDEADBEEF);
        req_addr = 32'h20; req_write = 1'b0; req_size = 2'b10; req_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_hold_rdata", d_rdata, 32'hDEADBEEF);
        chk("bp_hold_valid", 32'(d_valid), 32'd1);
        chk("bp_hold_ready", 32'(d_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_idle_after_hs", 32'(d_busy), 32'd0);
        @(posedge clk); #1;
        chk("bp_accept_next", 32'(d_busy), 32'd1);
        req_valid = 1'b0;
        recv(0, rd, er, n);
        chk("bp_second_rdata", rd, 32'h11AA3344);

        send(32'h30, 1'b1, 2'b00, 32'h55);
        @(negedge clk) rst = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk) rst = 1'b1;
        xact("rst_wait_ld30", 32'h30, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

        send(32'h31, 1'b1, 2'b00, 32'h66);
        n = 0;
        do begin @(negedge clk); n++; end while (!d_valid && n < 50);
        rst = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk) rst = 1'b1;
        xact("rst_resp_ld31", 32'h31, 1'b0, 2'b00, 32'd0, 32'h66, 1'b0);

        random_phase(400);

        sel = 1'b1;
        send(32'h30, 1'b1, 2'b10, 32'h00000000);
        recv(0, rd, er, n);
        chk("lat0_latency", 32'(n), 32'd2);
        send(32'h30, 1'b1, 2'b00, 32'h55);
        @(negedge clk) rst = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk) rst = 1'b1;
        xact("lat0_ld30", 32'h30, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        xact("lat0_st34", 32'h34, 1'b1, 2'b01, 32'hCAFE, 32'd0, 1'b0);
        xact("lat0_ld34", 32'h34, 1'b0, 2'b10, 32'd0, 32'h0000CAFE, 1'b0);

        random_phase(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
